sram_top: RTL and testbench
===========================

Name: sram_top

Overview:
- Small synchronous SRAM macro wrapper: serial-in loading, parallel word write, parallel word read.
- A serial-to-parallel shift register assembles a COLS-bit word, MSB first.
- w_en commits the assembled word to the addressed row; r_en reads a row into a registered output with a one-cycle valid strobe.
- Sits between a serial configuration/test interface and the digital core of the mixed-signal SRAM.

Parameters:
- ROWS, 4, address width in bits; memory depth = 2**ROWS words.
- COLS, 8, word width in bits; shift register and data_out width.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- arst_n  input  1  reset, synchronous, active-low (port name kept per codebase convention despite synchronous behaviour).
- serial_in  input  1  serial data bit, sampled when shift=1.
- shift  input  1  shift-enable for the input shift register.
- w_en  input  1  write strobe: store the shift register into mem[addr].
- r_en  input  1  read strobe: load mem[addr] into data_out.
- addr  input  ROWS  row address, used by both write and read.
- data_out  output  COLS  registered read data.
- data_valid  output  1  one-cycle pulse marking new data_out.

Behaviour:
- Reset: on a rising edge with arst_n=0:
  - shift register <= 0, data_out <= 0, data_valid <= 0.
  - All memory words <= 0.
  - Reset overrides every other input in that cycle.
- Shift: when shift=1, sreg <= {sreg[COLS-2:0], serial_in}.
  - After COLS consecutive shift cycles, the first bit sent sits in sreg[COLS-1] (MSB-first load).
  - When shift=0, sreg holds.
  - No bit counter: extra shifts push the oldest bits out; fewer shifts leave old bits in the low positions.
- Write: when w_en=1, mem[addr] <= sreg, using the sreg value before any same-cycle shift.
  - Write occupies a single cycle; no handshake or backpressure.
  - w_en held for N cycles rewrites the same value N times; harmless.
- Read: when r_en=1, data_out <= mem[addr] and data_valid <= 1 on the same edge (latency one clock from r_en sampled).
  - When r_en=0, data_valid <= 0 and data_out holds its last value.
  - r_en held for N cycles gives N consecutive valid cycles, each tracking the current addr.
- Simultaneous w_en and r_en:
  - Both execute.
  - The read returns the old contents of mem[addr] (read-before-write).
  - The new value is visible on the next read.
- addr is fully decoded; every value 0..2**ROWS-1 is a valid row; no out-of-range case.
- Memory is behavioural flop/array storage, no initial contents other than reset clear.
- Reset asserted mid-shift discards partial words. Reset asserted mid-read clears data_valid and data_out on that edge.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- When defined:
  - Each row stores an extra even-parity bit computed from sreg at write time.
  - New output parity_err (1 bit, reset 0) is registered alongside data_out on every read.
  - parity_err = 1 when the recomputed parity of the read word mismatches the stored bit.
  - parity_err is cleared on any cycle with r_en=0.
  - Stored parity bits reset to 0, consistent with the zero data.
- When undefined: no parity storage and no parity_err port; the block is exactly as above.

Test Plan:
- Reset then read: hold arst_n=0 two edges, release, read addr 0 -> data_out=0x00, data_valid high exactly one cycle.
- Basic write/read: shift 0xA5 MSB first (8 cycles), w_en one cycle at addr 3, r_en one cycle at addr 3 -> next edge data_out=0xA5, data_valid=1 one cycle.
- Address isolation: write 0x3C to addr 0 and 0xC3 to addr 15 -> reads return 0x3C and 0xC3; addr 3 still 0xA5.
- Read-before-write: addr 5 holds 0x11, shift in 0x22, assert w_en and r_en together -> data_out=0x11; following read -> 0x22.
- Overshift and hold: shift 10 bits 1,0,1,1,0,0,1,0,1,1 then write addr 7 -> read gives 0xCB (last 8 bits); idle 5 cycles -> data_out unchanged, data_valid=0.
- Reset mid-operation and parity: assert reset after 4 shift bits -> sreg and all rows read 0. With SRAM_PARITY_EN, a forced bit flip in stored row 3 -> parity_err=1 on read.

Source files
------------

// File: rtl/sram_top.sv
// Serial-load SRAM wrapper: MSB-first shift register, word write, registered read.
// Optional SRAM_PARITY_EN adds a stored even-parity bit and a parity_err output.
module sram_top #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            serial_in,
  input  logic            shift,
  input  logic            w_en,
  input  logic            r_en,
  input  logic [ROWS-1:0] addr,
  output logic [COLS-1:0] data_out,
`ifdef SRAM_PARITY_EN
  output logic            parity_err,
`endif
  output logic            data_valid
);

  localparam int DEPTH = 2**ROWS;

  logic [COLS-1:0] sreg;
  logic [COLS-1:0] mem [DEPTH];

  // Nonblocking updates give read-before-write on a shared address
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      sreg       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (shift)
        sreg <= {sreg[COLS-2:0], serial_in};
      if (w_en)
        mem[addr] <= sreg;
      data_valid <= r_en;
      if (r_en)
        data_out <= mem[addr];
    end
  end

`ifdef SRAM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      parity_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        par[i] <= 1'b0;
    end else begin
      if (w_en)
        par[addr] <= ^sreg;
      parity_err <= r_en && ((^mem[addr]) != par[addr]);
    end
  end
`endif

endmodule

// File: tb/tb_sram_top.sv
// Scoreboard bench for sram_top; reads queue expected words, checked at output.
// Parity checks are compiled in when SRAM_PARITY_EN is defined.
module tb_sram_top;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       serial_in;
  logic       shift;
  logic       w_en;
  logic       r_en;
  logic [3:0] addr;
  logic [7:0] data_out;
  logic       data_valid;
`ifdef SRAM_PARITY_EN
  logic       parity_err;
`endif

  sram_top #(.ROWS(4), .COLS(8)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .serial_in(serial_in),
    .shift(shift),
    .w_en(w_en),
    .r_en(r_en),
    .addr(addr),
    .data_out(data_out),
`ifdef SRAM_PARITY_EN
    .parity_err(parity_err),
`endif
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] m_mem [16];
  logic       m_bad [16];
  logic [7:0] m_sreg;
  logic [7:0] last;
  logic [7:0] q [$];
  logic       q_perr [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic sh, input logic sin,
                      input logic we, input logic re, input logic [3:0] a);
    logic       ev;
    logic [7:0] e;
    logic       ep;
    arst_n    = rn;
    shift     = sh;
    serial_in = sin;
    w_en      = we;
    r_en      = re;
    addr      = a;
    ev = rn && re;
    if (!rn) begin
      m_sreg = '0;
      last   = '0;
      for (int i = 0; i < 16; i++) begin
        m_mem[i] = '0;
        m_bad[i] = 1'b0;
      end
    end else begin
      if (re) begin
        q.push_back(m_mem[a]);
        q_perr.push_back(m_bad[a]);
      end
      if (we) begin
        m_mem[a] = m_sreg;
        m_bad[a] = 1'b0;
      end
      if (sh)
        m_sreg = {m_sreg[6:0], sin};
    end
    @(posedge clk);
    #1;
    check("valid", {31'd0, data_valid}, {31'd0, ev});
    ep = 1'b0;
    if (ev) begin
      if (q.size() == 0) begin
        check("queue_empty", 32'd1, 32'd0);
      end else begin
        e  = q.pop_front();
        ep = q_perr.pop_front();
        check("rdata", {24'd0, data_out}, {24'd0, e});
        last = e;
      end
    end else begin
      check("hold", {24'd0, data_out}, {24'd0, last});
    end
`ifdef SRAM_PARITY_EN
    check("perr", {31'd0, parity_err}, {31'd0, ep});
`endif
    @(negedge clk);
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      step(1'b1, 1'b1, b[i], 1'b0, 1'b0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  logic [9:0] over_bits;

  initial begin
    arst_n    = 1'b0;
    shift     = 1'b0;
    serial_in = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    addr      = '0;
    m_sreg    = '0;
    last      = '0;
    @(negedge clk);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rd(4'd0);
    idle();

    shift_byte(8'hA5);
    wr(4'd3);
    rd(4'd3);
    idle();

    shift_byte(8'h3C);
    wr(4'd0);
    shift_byte(8'hC3);
    wr(4'd15);
    rd(4'd0);
    rd(4'd15);
    rd(4'd3);
    idle();

    shift_byte(8'h11);
    wr(4'd5);
    shift_byte(8'h22);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    rd(4'd5);
    idle();

    over_bits = 10'b1011001011;
    for (int i = 9; i >= 0; i--)
      step(1'b1, 1'b1, over_bits[i], 1'b0, 1'b0, 4'd0);
    wr(4'd7);
    rd(4'd7);
    check("overshift", {24'd0, data_out}, 32'h0000_00CB);
    repeat (5) idle();

    // shift while writing: write must take the pre-shift value
    shift_byte(8'h5A);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd9);
    rd(4'd9);
    idle();

`ifdef SRAM_PARITY_EN
    dut.mem[3][0] = ~dut.mem[3][0];
    m_mem[3][0] = ~m_mem[3][0];
    m_bad[3] = 1'b1;
    rd(4'd3);
    idle();
    shift_byte(8'hA5);
    wr(4'd3);
    rd(4'd3);
    idle();
`endif

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
    wr(4'd9);
    rd(4'd9);
    rd(4'd3);
    rd(4'd15);
    rd(4'd7);
    idle();

    check("queue_left", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
